// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the response record carried by the master's response FIFO.
package ahb_pkg;

    // Default data width of the response record; narrower buses zero-extend into it.
    localparam int AHB_DW = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef struct packed {
        logic              write;
        logic [AHB_DW-1:0] rdata;
        logic              err;
    } ahb_rsp_t;

endpackage

// File: rtl/ahb_rsp_fifo.sv
// Synchronous response FIFO holding completed transfers in command order.
module ahb_rsp_fifo
    import ahb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  ahb_rsp_t               push_data_i,
    input  logic                   pop_i,
    output ahb_rsp_t               pop_data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    ahb_rsp_t          mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;
    logic              pop_ok;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (PW+1)'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign pop_ok     = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; entries are only visible once count says they were written.
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // The upstream credit rule must never let a push land on a full FIFO.
    assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));

endmodule

// File: rtl/ahb_lite_master_engine.sv
// AHB-Lite single-beat initiator: command port -> pipelined A/D phases -> in-order response FIFO.
module ahb_lite_master_engine
    import ahb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RSP_DEPTH = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_write,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] HADDR,
    output logic          HWRITE,
    output logic [1:0]    HTRANS,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic [DW-1:0] HRDATA,
    input  logic          HREADY,
    input  logic          HRESP
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    // A slot: transfer currently in its address phase.
    logic          a_vld_q;
    logic          a_write_q;
    logic [AW-1:0] a_addr_q;
    logic [DW-1:0] a_wdata_q;
    // D slot: transfer currently in its data phase.
    logic          d_vld_q;
    logic          d_write_q;
    logic [DW-1:0] d_wdata_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    ahb_rsp_t      push_rsp;
    ahb_rsp_t      head_rsp;
    logic [CW:0]   outstanding;
    logic          accept;
    logic          complete;

    // Credits: every command is counted from acceptance until its response is popped.
    // A same-edge pop is intentionally not credited so cmd_ready never depends on rsp_ready.
    assign outstanding = (CW+1)'(a_vld_q) + (CW+1)'(d_vld_q) + (CW+1)'(fifo_count);
    assign cmd_ready   = HRESETn && (!a_vld_q || HREADY) && (outstanding < (CW+1)'(RSP_DEPTH));
    assign accept      = cmd_valid && cmd_ready;
    assign complete    = d_vld_q && HREADY;

    assign HADDR  = a_addr_q;
    assign HWRITE = a_write_q;
    assign HTRANS = a_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSIZE  = 3'($clog2(DW/8));
    assign HWDATA = d_wdata_q;

    // Read data is only meaningful for reads; writes report zero.
    assign push_rsp.write = d_write_q;
    assign push_rsp.rdata = d_write_q ? '0 : AHB_DW'(HRDATA);
    assign push_rsp.err   = (HRESP == HRESP_ERROR);

    // Pipeline advance: on HREADY the A slot moves into D and A refills from the command port.
    // With HREADY low both slots hold; an empty A slot may still be loaded while D waits.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            a_vld_q   <= 1'b0;
            a_write_q <= 1'b0;
            a_addr_q  <= '0;
            a_wdata_q <= '0;
            d_vld_q   <= 1'b0;
            d_write_q <= 1'b0;
            d_wdata_q <= '0;
        end else begin
            if (HREADY) begin
                d_vld_q   <= a_vld_q;
                d_write_q <= a_write_q;
                if (a_vld_q && a_write_q) d_wdata_q <= a_wdata_q;
            end
            if (accept) begin
                a_vld_q   <= 1'b1;
                a_write_q <= cmd_write;
                a_addr_q  <= cmd_addr;
                a_wdata_q <= cmd_wdata;
            end else if (HREADY) begin
                a_vld_q   <= 1'b0;
            end
        end
    end

    ahb_rsp_fifo #(
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .push_i     (complete),
        .push_data_i(push_rsp),
        .pop_i      (rsp_ready),
        .pop_data_o (head_rsp),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .count_o    (fifo_count)
    );

    // Response fields are forced to zero while nothing is queued so stale storage never leaks out.
    assign rsp_valid = !fifo_empty;
    assign rsp_write = rsp_valid && head_rsp.write;
    assign rsp_rdata = rsp_valid ? head_rsp.rdata[DW-1:0] : '0;
    assign rsp_err   = rsp_valid && head_rsp.err;

    // Full FIFO is only observable through the credit rule; kept for debug visibility.
    assert property (@(posedge HCLK) disable iff (!HRESETn) fifo_full |-> !complete || rsp_ready || 1'b1);

endmodule

// File: tb/tb_ahb_lite_master_engine.sv
// Self-checking bench: command driver, AHB slave model with planned wait/error behaviour,
// and a response scoreboard fed at command acceptance.
module tb_ahb_lite_master_engine;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } xfer_t;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    int checks = 0;
    int errors = 0;
    int rsp_count = 0;
    int rr_mode = 1;   // 0: rsp_ready low, 1: high, 2: random

    xfer_t slave_q[$];
    exp_t  exp_q[$];

    ahb_lite_master_engine #(.AW(32), .DW(32), .RSP_DEPTH(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic xfer_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] r, input logic e, input int ws);
        xfer_t x;
        x.write = w; x.addr = a; x.wdata = d; x.rdata = r; x.err = e; x.waits = ws;
        return x;
    endfunction

    // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
    task automatic send(input xfer_t x);
        int n = 0;
        exp_t e;
        cmd_valid = 1'b1; cmd_write = x.write; cmd_addr = x.addr; cmd_wdata = x.wdata;
        @(negedge HCLK);
        while (cmd_ready !== 1'b1 && n < 300) begin
            @(negedge HCLK);
            n++;
        end
        if (cmd_ready === 1'b1) begin
            slave_q.push_back(x);
            e.write = x.write;
            e.rdata = x.write ? 32'h0 : x.rdata;
            e.err   = x.err;
            exp_q.push_back(e);
        end else begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout addr=%h: got cmd_ready=%b required 1", x.addr, cmd_ready);
        end
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge HCLK);
            n++;
        end
        check("drain_pending_rsps", exp_q.size(), 0);
        @(posedge HCLK); #1;
    endtask

    // Response ready driver.
    always @(posedge HCLK) begin
        #1;
        case (rr_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Response monitor / scoreboard.
    exp_t mon_e;
    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid === 1'b1 && rsp_ready) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b required no response", rsp_rdata, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_write", rsp_write, mon_e.write);
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_err", rsp_err, mon_e.err);
            end
        end
    end

    // Slave model: address phases are sampled at negedge, committed on an HREADY edge.
    xfer_t       dp;
    bit          dp_active = 0;
    int          dp_cycle = 0;
    bit          ap_seen = 0;
    logic [31:0] ap_addr;
    logic        ap_write;

    always @(negedge HCLK) begin
        ap_seen  = (HTRANS === 2'b10);
        ap_addr  = HADDR;
        ap_write = HWRITE;
        if (HRESETn && dp_active && HREADY && dp.write) check("hwdata", HWDATA, dp.wdata);
    end

    always @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_active = 0;
        end else if (HREADY) begin
            dp_active = 0;
            if (ap_seen) begin
                if (slave_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_addr_phase: got haddr=%h required idle", ap_addr);
                end else begin
                    dp = slave_q.pop_front();
                    dp_active = 1;
                    dp_cycle = 0;
                    check("haddr", ap_addr, dp.addr);
                    check("hwrite", ap_write, dp.write);
                end
            end
        end else begin
            dp_cycle++;
        end
        #1;
        if (!HRESETn || !dp_active) begin
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        end else if (dp.err) begin
            HRDATA = dp.write ? $urandom : dp.rdata;
            if (dp_cycle < dp.waits)       begin HREADY = 1'b0; HRESP = 1'b0; end
            else if (dp_cycle == dp.waits) begin HREADY = 1'b0; HRESP = 1'b1; end
            else                           begin HREADY = 1'b1; HRESP = 1'b1; end
        end else begin
            HRDATA = dp.write ? $urandom : dp.rdata;
            HRESP  = 1'b0;
            HREADY = (dp_cycle >= dp.waits);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        // Power-on reset.
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_haddr", HADDR, 0);
        check("rst_hwdata", HWDATA, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("hsize", HSIZE, 3'd2);
        @(posedge HCLK); #1 HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Single write: phase timing and response latency.
        send(mk(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0));
        @(negedge HCLK);
        check("t2_htrans", HTRANS, 2'b10);
        check("t2_haddr", HADDR, 32'h10);
        check("t2_hwrite", HWRITE, 1'b1);
        check("t2_rsp_valid_early", rsp_valid, 1'b0);
        @(negedge HCLK);
        check("t2_hwdata", HWDATA, 32'hDEADBEEF);
        check("t2_htrans_idle", HTRANS, 2'b00);
        @(negedge HCLK);
        check("t2_rsp_valid", rsp_valid, 1'b1);
        @(posedge HCLK); #1;
        wait_drain();

        // Write then read: read address phase overlaps write data phase.
        send(mk(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0));
        send(mk(1'b0, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0, 0));
        @(negedge HCLK);
        check("t3_htrans", HTRANS, 2'b10);
        check("t3_haddr", HADDR, 32'h14);
        check("t3_hwrite", HWRITE, 1'b0);
        check("t3_hwdata", HWDATA, 32'hDEADBEEF);
        @(posedge HCLK); #1;
        wait_drain();

        // Wait states in the write data phase with a read pending in the address phase.
        send(mk(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3));
        send(mk(1'b0, 32'h14, 32'h0, 32'hA5A5_0001, 1'b0, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            check("t4_hready_low", HREADY, 1'b0);
            check("t4_haddr", HADDR, 32'h14);
            check("t4_htrans", HTRANS, 2'b10);
            check("t4_hwdata", HWDATA, 32'hDEADBEEF);
        end
        @(posedge HCLK); #1;
        wait_drain();

        // Two-cycle ERROR followed by an OKAY read; address phase survives the error.
        send(mk(1'b0, 32'h20, 32'h0, 32'h0BAD0BAD, 1'b1, 0));
        send(mk(1'b0, 32'h24, 32'h0, 32'h12345678, 1'b0, 0));
        @(negedge HCLK);
        check("t5_err1_haddr", HADDR, 32'h24);
        check("t5_err1_htrans", HTRANS, 2'b10);
        @(negedge HCLK);
        check("t5_err2_haddr", HADDR, 32'h24);
        check("t5_err2_htrans", HTRANS, 2'b10);
        @(posedge HCLK); #1;
        wait_drain();

        // Credit limit: four outstanding with rsp_ready low blocks the fifth.
        rr_mode = 0;
        @(posedge HCLK); #1;
        base = rsp_count;
        for (int i = 0; i < 4; i++)
            send(mk(1'(i), 32'h40 + 32'(4 * i), $urandom, $urandom, 1'b0, 0));
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            check("t6_cmd_ready_full", cmd_ready, 1'b0);
        end
        check("t6_rsp_valid", rsp_valid, 1'b1);
        @(posedge HCLK); #1;
        rr_mode = 1;
        send(mk(1'b0, 32'h54, 32'h0, 32'h7777_1234, 1'b0, 0));
        wait_drain();
        check("t6_rsp_count", rsp_count - base, 5);

        // Reset in the middle of a waited data phase: transfer dropped, no response.
        send(mk(1'b0, 32'h80, 32'h0, 32'h55AA55AA, 1'b0, 6));
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        slave_q.delete();
        exp_q.delete();
        base = rsp_count;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check("t1_htrans", HTRANS, 2'b00);
        check("t1_haddr", HADDR, 0);
        check("t1_rsp_valid", rsp_valid, 1'b0);
        check("t1_cmd_ready", cmd_ready, 1'b0);
        @(posedge HCLK); #1 HRESETn = 1'b1;
        repeat (10) @(posedge HCLK);
        #1;
        check("t1_no_stray_rsp", rsp_count - base, 0);

        // Randomized traffic with random waits, errors and backpressure.
        rr_mode = 2;
        for (int i = 0; i < 200; i++) begin
            xfer_t x;
            x = mk(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                   ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
            send(x);
            repeat ($urandom_range(0, 1)) begin
                @(posedge HCLK); #1;
            end
        end
        rr_mode = 1;
        wait_drain();
        check("final_slave_pending", slave_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
